// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue: in-order tracker for in-flight conditional branches.
// Decode allocates entries at the tail, execute resolves them in any order,
// and the head retires in program order. Each retire sends one feedback pulse
// to the predictor. A mispredicted head also requests a pipeline flush and
// empties the queue.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_resolution_queue #(
  parameter int  DEPTH = 8,
  parameter int  AW    = `ADDR_WIDTH,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_alloc_valid,
  input  logic [AW-1:0] i_alloc_pc,
  input  logic          i_alloc_prediction,
  input  logic [AW-1:0] i_alloc_recovery_target,
  output logic          o_alloc_ready,
  output logic [TW-1:0] o_alloc_tag,
  input  logic          i_res_valid,
  input  logic [TW-1:0] i_res_tag,
  input  logic          i_res_outcome,
  output logic          o_fb_valid,
  output logic [AW-1:0] o_fb_pc,
  output logic          o_fb_prediction,
  output logic          o_fb_outcome,
  output logic          o_flush,
  output logic [AW-1:0] o_flush_target,
  output logic [TW:0]   o_count
);

  typedef enum logic [1:0] {
    ENT_FREE     = 2'd0,
    ENT_PENDING  = 2'd1,
    ENT_RESOLVED = 2'd2
  } entry_state_e;

  localparam logic [TW:0] PtrOne = {{TW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit, which separates full from empty
  logic [TW:0]   headPtr_q, headPtr_d;
  logic [TW:0]   tailPtr_q, tailPtr_d;
  logic [TW-1:0] headIdx;
  logic [TW-1:0] tailIdx;
  logic [TW:0]   occupancy;
  logic          queueFull;

  entry_state_e  entState_q [DEPTH];
  entry_state_e  entState_d [DEPTH];
  logic [AW-1:0] entPc_q     [DEPTH];
  logic [AW-1:0] entTarget_q [DEPTH];
  logic          entPred_q   [DEPTH];
  logic          entOutcome_q[DEPTH];

  logic          retire;
  logic          mispredict;
  logic          allocFire;
  logic          resolveFire;

  logic          fbValid_q;
  logic [AW-1:0] fbPc_q;
  logic          fbPred_q;
  logic          fbOutcome_q;
  logic          flush_q;
  logic [AW-1:0] flushTarget_q;

  // Occupancy, full detection and per-edge events, all decoded from pre-edge state
  always_comb begin
    headIdx     = headPtr_q[TW-1:0];
    tailIdx     = tailPtr_q[TW-1:0];
    occupancy   = tailPtr_q - headPtr_q;
    queueFull   = (headIdx == tailIdx) && (headPtr_q[TW] != tailPtr_q[TW]);
    retire      = (entState_q[headIdx] == ENT_RESOLVED);
    mispredict  = retire && (entOutcome_q[headIdx] != entPred_q[headIdx]);
    allocFire   = i_alloc_valid && !queueFull && !mispredict;
    resolveFire = i_res_valid && (entState_q[i_res_tag] == ENT_PENDING) && !mispredict;
  end

  // Next entry states and pointers; a mispredict retire overrides everything else
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entState_d[i] = entState_q[i];
    end
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        entState_d[i] = ENT_FREE;
      end
      headPtr_d = headPtr_q + PtrOne;
      tailPtr_d = headPtr_q + PtrOne;
    end else begin
      if (retire) begin
        entState_d[headIdx] = ENT_FREE;
        headPtr_d           = headPtr_q + PtrOne;
      end
      if (resolveFire) begin
        entState_d[i_res_tag] = ENT_RESOLVED;
      end
      if (allocFire) begin
        entState_d[tailIdx] = ENT_PENDING;
        tailPtr_d           = tailPtr_q + PtrOne;
      end
    end
  end

  // Entry states and pointers; reset drops every in-flight branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entState_q[i] <= ENT_FREE;
      end
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      for (int i = 0; i < DEPTH; i++) begin
        entState_q[i] <= entState_d[i];
      end
    end
  end

  // Entry payload needs no reset because a FREE state marks it as meaningless
  always_ff @(posedge clk) begin
    if (allocFire) begin
      entPc_q[tailIdx]     <= i_alloc_pc;
      entPred_q[tailIdx]   <= i_alloc_prediction;
      entTarget_q[tailIdx] <= i_alloc_recovery_target;
    end
    if (resolveFire) begin
      entOutcome_q[i_res_tag] <= i_res_outcome;
    end
  end

  // Registered retire outputs; the data fields hold their last value between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbValid_q     <= 1'b0;
      fbPc_q        <= '0;
      fbPred_q      <= 1'b0;
      fbOutcome_q   <= 1'b0;
      flush_q       <= 1'b0;
      flushTarget_q <= '0;
    end else begin
      fbValid_q <= retire;
      flush_q   <= mispredict;
      if (retire) begin
        fbPc_q      <= entPc_q[headIdx];
        fbPred_q    <= entPred_q[headIdx];
        fbOutcome_q <= entOutcome_q[headIdx];
      end
      if (mispredict) begin
        flushTarget_q <= entTarget_q[headIdx];
      end
    end
  end

  // Drive the output ports from the pointers and the registered retire outputs
  always_comb begin
    o_alloc_ready   = !queueFull;
    o_alloc_tag     = tailIdx;
    o_count         = occupancy;
    o_fb_valid      = fbValid_q;
    o_fb_pc         = fbPc_q;
    o_fb_prediction = fbPred_q;
    o_fb_outcome    = fbOutcome_q;
    o_flush         = flush_q;
    o_flush_target  = flushTarget_q;
  end

endmodule

// File: tb/tb_branch_resolution_queue.sv
// tb_branch_resolution_queue: directed scenarios against a queue-based model
// of the branch resolution queue, with a few literal checkpoints per scenario.

module tb_branch_resolution_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          allocValid = 1'b0;
  logic [AW-1:0] allocPc = '0;
  logic          allocPred = 1'b0;
  logic [AW-1:0] allocTgt = '0;
  logic          allocReady;
  logic [TW-1:0] allocTag;
  logic          resValid = 1'b0;
  logic [TW-1:0] resTag = '0;
  logic          resOutcome = 1'b0;
  logic          fbValid;
  logic [AW-1:0] fbPc;
  logic          fbPred;
  logic          fbOutcome;
  logic          flush;
  logic [AW-1:0] flushTarget;
  logic [TW:0]   count;

  int errCount   = 0;
  int checkCount = 0;
  bit checkEn    = 1'b0;

  branch_resolution_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_alloc_valid           (allocValid),
    .i_alloc_pc              (allocPc),
    .i_alloc_prediction      (allocPred),
    .i_alloc_recovery_target (allocTgt),
    .o_alloc_ready           (allocReady),
    .o_alloc_tag             (allocTag),
    .i_res_valid             (resValid),
    .i_res_tag               (resTag),
    .i_res_outcome           (resOutcome),
    .o_fb_valid              (fbValid),
    .o_fb_pc                 (fbPc),
    .o_fb_prediction         (fbPred),
    .o_fb_outcome            (fbOutcome),
    .o_flush                 (flush),
    .o_flush_target          (flushTarget),
    .o_count                 (count)
  );

  always #5 clk = ~clk;

  // Model: program-ordered list of in-flight branches plus the next tag to hand out
  typedef struct {
    logic [AW-1:0] pc;
    logic          pred;
    logic [AW-1:0] tgt;
    int            tag;
    bit            resolved;
    logic          outcome;
  } entry_t;

  entry_t        mq[$];
  int            mNextTag   = 0;
  logic          mFbValid   = 1'b0;
  logic [AW-1:0] mFbPc      = '0;
  logic          mFbPred    = 1'b0;
  logic          mFbOutcome = 1'b0;
  logic          mFlush     = 1'b0;
  logic [AW-1:0] mFlushTgt  = '0;

  task automatic modelClear();
    mq.delete();
    mNextTag   = 0;
    mFbValid   = 1'b0;
    mFbPc      = '0;
    mFbPred    = 1'b0;
    mFbOutcome = 1'b0;
    mFlush     = 1'b0;
    mFlushTgt  = '0;
  endtask

  task automatic modelStep();
    int  preSize;
    bit  doRetire;
    bit  wrong;
    entry_t e;
    preSize  = mq.size();
    doRetire = (preSize > 0) && mq[0].resolved;
    wrong    = doRetire && (mq[0].outcome != mq[0].pred);
    mFbValid = doRetire;
    mFlush   = wrong;
    if (doRetire) begin
      mFbPc      = mq[0].pc;
      mFbPred    = mq[0].pred;
      mFbOutcome = mq[0].outcome;
    end
    if (wrong) begin
      mFlushTgt = mq[0].tgt;
      mNextTag  = (mq[0].tag + 1) % DEPTH;
      mq.delete();
    end else begin
      if (resValid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].tag == int'(resTag) && !mq[i].resolved) begin
            mq[i].resolved = 1'b1;
            mq[i].outcome  = resOutcome;
          end
        end
      end
      if (doRetire) void'(mq.pop_front());
      if (allocValid && preSize < DEPTH) begin
        e.pc       = allocPc;
        e.pred     = allocPred;
        e.tgt      = allocTgt;
        e.tag      = mNextTag;
        e.resolved = 1'b0;
        e.outcome  = 1'b0;
        mq.push_back(e);
        mNextTag = (mNextTag + 1) % DEPTH;
      end
    end
  endtask

  // Advance the model on every clock edge, or clear it as soon as reset asserts
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelClear();
      else modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model in the middle of each cycle
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("m_alloc_ready", 64'(allocReady), 64'(mq.size() < DEPTH));
        checkOutput("m_alloc_tag", 64'(allocTag), 64'(mNextTag));
        checkOutput("m_count", 64'(count), 64'(mq.size()));
        checkOutput("m_fb_valid", 64'(fbValid), 64'(mFbValid));
        checkOutput("m_fb_pc", 64'(fbPc), 64'(mFbPc));
        checkOutput("m_fb_pred", 64'(fbPred), 64'(mFbPred));
        checkOutput("m_fb_outcome", 64'(fbOutcome), 64'(mFbOutcome));
        checkOutput("m_flush", 64'(flush), 64'(mFlush));
        if (mFlush) checkOutput("m_flush_target", 64'(flushTarget), 64'(mFlushTgt));
      end
    end
  end

  // Drive one edge worth of inputs, then stop 1ns after the edge
  task automatic applyStimulus(input logic aValid, input logic [AW-1:0] aPc, input logic aPred,
                               input logic [AW-1:0] aTgt, input logic rValid,
                               input logic [TW-1:0] rTag, input logic rOut);
    allocValid = aValid;
    allocPc    = aPc;
    allocPred  = aPred;
    allocTgt   = aTgt;
    resValid   = rValid;
    resTag     = rTag;
    resOutcome = rOut;
    @(posedge clk);
    #1;
    allocValid = 1'b0;
    resValid   = 1'b0;
  endtask

  task automatic doAlloc(input logic [AW-1:0] pc, input logic pred, input logic [AW-1:0] tgt);
    applyStimulus(1'b1, pc, pred, tgt, 1'b0, '0, 1'b0);
  endtask

  task automatic doResolve(input logic [TW-1:0] tag, input logic outc);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, tag, outc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_ready", 64'(allocReady), 64'd1);
    checkOutput("rst_tag", 64'(allocTag), 64'd0);
    checkOutput("rst_fb_valid", 64'(fbValid), 64'd0);
    checkOutput("rst_flush", 64'(flush), 64'd0);
    checkOutput("rst_flush_target", 64'(flushTarget), 64'd0);
    checkOutput("rst_fb_pc", 64'(fbPc), 64'd0);
    checkEn = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Watchdog so the run always ends even if the stimulus sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    applyReset();

    // Single correctly predicted branch: feedback two edges after the resolve
    doAlloc(32'h100, 1'b0, 32'h104);
    checkOutput("s1_count_after_alloc", 64'(count), 64'd1);
    checkOutput("s1_tag_after_alloc", 64'(allocTag), 64'd1);
    doResolve(3'd0, 1'b0);
    checkOutput("s1_fb_not_yet", 64'(fbValid), 64'd0);
    idle(1);
    checkOutput("s1_fb_valid", 64'(fbValid), 64'd1);
    checkOutput("s1_fb_pc", 64'(fbPc), 64'h100);
    checkOutput("s1_flush", 64'(flush), 64'd0);
    checkOutput("s1_count", 64'(count), 64'd0);
    idle(1);
    checkOutput("s1_fb_drop", 64'(fbValid), 64'd0);
    checkOutput("s1_fb_pc_hold", 64'(fbPc), 64'h100);

    // Out-of-order resolves retire in program order
    applyReset();
    for (int i = 0; i < 3; i++) doAlloc(32'h200 + 32'(4 * i), 1'b1, 32'h900);
    doResolve(3'd2, 1'b1);
    doResolve(3'd1, 1'b1);
    doResolve(3'd0, 1'b1);
    checkOutput("s2_no_fb_yet", 64'(fbValid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("s2_fb_valid", 64'(fbValid), 64'd1);
      checkOutput("s2_fb_pc", 64'(fbPc), 64'(32'h200 + 32'(4 * i)));
    end
    checkOutput("s2_count", 64'(count), 64'd0);
    idle(1);
    checkOutput("s2_fb_end", 64'(fbValid), 64'd0);

    // Full queue, ignored allocation, same-edge retire and wrap of the tail
    applyReset();
    for (int i = 0; i < DEPTH; i++) doAlloc(32'h300 + 32'(4 * i), 1'b0, 32'h800);
    checkOutput("s3_ready_full", 64'(allocReady), 64'd0);
    checkOutput("s3_count_full", 64'(count), 64'd8);
    checkOutput("s3_tag_wrapped", 64'(allocTag), 64'd0);
    doAlloc(32'h999, 1'b0, 32'h0);
    checkOutput("s3_ninth_ignored", 64'(count), 64'd8);
    doResolve(3'd0, 1'b0);
    checkOutput("s3_count_resolved", 64'(count), 64'd8);
    doAlloc(32'h500, 1'b0, 32'h0);
    checkOutput("s3_retire_count", 64'(count), 64'd7);
    checkOutput("s3_retire_ready", 64'(allocReady), 64'd1);
    checkOutput("s3_retire_tag", 64'(allocTag), 64'd0);
    checkOutput("s3_retire_fb_pc", 64'(fbPc), 64'h300);
    doAlloc(32'h504, 1'b0, 32'h0);
    checkOutput("s3_refill_count", 64'(count), 64'd8);
    checkOutput("s3_refill_tag", 64'(allocTag), 64'd1);
    doResolve(3'd1, 1'b0);
    applyStimulus(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 3'd2, 1'b0);
    checkOutput("s3_sim1_count", 64'(count), 64'd7);
    checkOutput("s3_sim1_fb_pc", 64'(fbPc), 64'h304);
    applyStimulus(1'b1, 32'h604, 1'b0, 32'h0, 1'b1, 3'd3, 1'b0);
    checkOutput("s3_sim2_count", 64'(count), 64'd7);
    checkOutput("s3_sim2_tag", 64'(allocTag), 64'd2);
    checkOutput("s3_sim2_fb_pc", 64'(fbPc), 64'h308);
    idle(1);
    checkOutput("s3_sim3_count", 64'(count), 64'd6);
    checkOutput("s3_sim3_fb_pc", 64'(fbPc), 64'h30c);

    // Mispredicted head flushes the queue and discards same-edge requests
    applyReset();
    doAlloc(32'h400, 1'b1, 32'h208);
    for (int i = 1; i < 4; i++) doAlloc(32'h400 + 32'(4 * i), 1'b0, 32'h700);
    doResolve(3'd0, 1'b0);
    applyStimulus(1'b1, 32'h777, 1'b0, 32'h0, 1'b1, 3'd1, 1'b0);
    checkOutput("s4_flush", 64'(flush), 64'd1);
    checkOutput("s4_fb_valid", 64'(fbValid), 64'd1);
    checkOutput("s4_flush_target", 64'(flushTarget), 64'h208);
    checkOutput("s4_fb_pred", 64'(fbPred), 64'd1);
    checkOutput("s4_fb_outcome", 64'(fbOutcome), 64'd0);
    checkOutput("s4_count", 64'(count), 64'd0);
    checkOutput("s4_tag", 64'(allocTag), 64'd1);
    doResolve(3'd2, 1'b0);
    idle(3);
    checkOutput("s4_late_resolve_fb", 64'(fbValid), 64'd0);
    checkOutput("s4_late_resolve_count", 64'(count), 64'd0);
    doAlloc(32'h440, 1'b0, 32'h0);
    checkOutput("s4_next_tag", 64'(allocTag), 64'd2);
    checkOutput("s4_next_count", 64'(count), 64'd1);

    // Reset in the middle of a cycle drops in-flight entries immediately
    applyReset();
    for (int i = 0; i < 5; i++) doAlloc(32'hA00 + 32'(4 * i), 1'b0, 32'h0);
    doResolve(3'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_async_count", 64'(count), 64'd0);
    checkOutput("s5_async_ready", 64'(allocReady), 64'd1);
    checkOutput("s5_async_tag", 64'(allocTag), 64'd0);
    checkOutput("s5_async_fb", 64'(fbValid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checkOutput("s5_no_fb_after", 64'(fbValid), 64'd0);
    end
    checkOutput("s5_count_after", 64'(count), 64'd0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/branch_resolution_queue.md
BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 SHALL take parameter DEPTH, default 8, number of in-flight branch entries (power of 2, >=2).
REQ-002 SHALL take parameter AW, default `ADDR_WIDTH, PC/target width.
REQ-003 SHALL use TW = log2(DEPTH) for tag width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_alloc_valid  in  1  decode allocates a conditional branch.
REQ-007 SHALL have port i_alloc_pc  in  AW  branch PC.
REQ-008 SHALL have port i_alloc_prediction  in  1  predicted outcome, 1=TAKEN.
REQ-009 SHALL have port i_alloc_recovery_target  in  AW  fetch address if prediction is wrong.
REQ-010 SHALL have port o_alloc_ready  out  1  entry available (count < DEPTH).
REQ-011 SHALL have port o_alloc_tag  out  TW  tag assigned on the next accepted allocation (= tail index).
REQ-012 SHALL have port i_res_valid  in  1  execute resolved a branch.
REQ-013 SHALL have port i_res_tag  in  TW  tag of the resolved branch.
REQ-014 SHALL have port i_res_outcome  in  1  actual outcome, 1=TAKEN.
REQ-015 SHALL have port o_fb_valid  out  1  one-cycle in-order predictor feedback pulse.
REQ-016 SHALL have ports o_fb_pc (out, AW), o_fb_prediction (out, 1), o_fb_outcome (out, 1): feedback fields of the retired entry.
REQ-017 SHALL have port o_flush  out  1  misprediction recovery pulse, coincident with o_fb_valid.
REQ-018 SHALL have port o_flush_target  out  AW  recovery fetch address.
REQ-019 SHALL have port o_count  out  TW+1  occupied entries.

Function
REQ-020 SHALL hold a circular buffer with head/tail pointers of TW+1 bits (wrap bit); full when indices match and wrap bits differ, empty when both are equal.
REQ-021 SHALL give each entry a state FREE, PENDING or RESOLVED.
REQ-022 SHALL accept an allocation at an edge where i_alloc_valid & o_alloc_ready: write pc/prediction/target into the tail entry, set it PENDING, and increment tail.
REQ-023 SHALL compute o_alloc_ready from pre-edge count only; a retire at the same edge does not free a slot for a same-edge allocation.
REQ-024 SHALL, at an edge with i_res_valid whose tagged entry is PENDING, store the outcome and set the entry RESOLVED; resolves of FREE or RESOLVED entries SHALL be ignored.
REQ-025 SHALL retire at most one entry per edge, only the head, and only when it is RESOLVED at that edge (pre-edge state).
REQ-026 SHALL register retire outputs: o_fb_valid = 1 for exactly the cycle following the retire edge, with o_fb_* = entry fields; o_fb_valid = 0 otherwise.
REQ-027 SHALL give a head resolve-to-feedback latency of 2 edges: resolve sampled at edge E, retire at E+1, o_fb_valid high during cycle E+1..E+2.
REQ-028 SHALL, on retiring an entry whose outcome != prediction, pulse o_flush with o_fb_valid, drive o_flush_target = recovery target, and at that same retire edge free all entries and set tail = head = retired index+1, leaving the queue empty.
REQ-029 SHALL discard any allocation or resolve sampled at a mispredict retire edge.
REQ-030 SHALL hold o_fb_pc, o_fb_prediction, o_fb_outcome and o_flush_target at last values when not pulsing.
REQ-031 SHALL handle simultaneous allocate, resolve and correct retire at one edge independently; o_count = count + alloc - retire.
REQ-032 SHALL wrap pointer indices modulo DEPTH, toggling the wrap bit on wrap.

Reset
REQ-033 SHALL, while rst_n = 0 (asynchronous), force all entries FREE, head = tail = 0, o_count = 0, o_alloc_tag = 0, o_alloc_ready = 1, o_fb_valid = 0, o_flush = 0, and o_fb_pc, o_fb_prediction, o_fb_outcome, o_flush_target = 0.
REQ-034 SHALL discard all in-flight entries on reset asserted mid-operation; no feedback emitted for them.

Verification
REQ-035 SHALL cover: allocate pc 0x100 pred 0, resolve outcome 0 -> o_fb_valid 2 edges later, o_fb_pc=0x100, o_flush=0, o_count back to 0.
REQ-036 SHALL cover: allocate tags 0,1,2; resolve 2,1 then 0 -> three consecutive fb pulses in order 0,1,2.
REQ-037 SHALL cover: allocate 8 entries -> o_alloc_ready=0, o_count=8; ninth alloc ignored; retire head -> ready=1, tag wraps to 0.
REQ-038 SHALL cover: tags 0..3 pending, tag 0 pred 1 resolved 0, target 0x208 -> o_flush=1, o_flush_target=0x208, o_count=0, later resolve of tag 2 ignored.
REQ-039 SHALL cover: 5 entries pending, rst_n low mid-cycle -> outputs reset immediately, no o_fb_valid after release.
